// File: rtl/sseg_scan_if.sv
// sseg_scan_if: bundles the hex value / per-digit controls going into the
// scanner together with the decoder-facing outputs coming out of it.
interface sseg_scan_if;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [3:0]  en;
  logic        lzb;
  logic [3:0]  num;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_start;

  // Side that supplies the value and watches the display drive.
  modport master (
    output din, dp_in, en, lzb,
    input  num, an, dp, digit_sel, frame_start
  );

  // The scanner itself.
  modport slave (
    input  din, dp_in, en, lzb,
    output num, an, dp, digit_sel, frame_start
  );
endinterface

// File: rtl/sseg_scan.sv
// sseg_scan: time-multiplexed 4-digit seven-segment scanner.
// Latches din/dp_in/en once per frame and walks digits 0..3, each slot
// starting with an all-anodes-off guard interval to suppress ghosting.
// Optional feature: define SSEG_SCAN_LZB_EN to enable leading-zero blanking.
module sseg_scan #(
  parameter int unsigned TICK_CYCLES  = 100000,
  parameter int unsigned GUARD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,   // asynchronous, active-low
  sseg_scan_if.slave  bus
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GRD = CW'(GUARD_CYCLES);

  typedef enum logic {PH_GUARD, PH_SHOW} phase_t;

  // Current state
  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  phase_t        phase;
  logic [15:0]   sh_din;
  logic [3:0]    sh_dp;
  logic [3:0]    sh_en;
  logic          load_pend;

  // Next state
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    digit_nxt;
  phase_t        phase_nxt;
  logic [15:0]   sh_din_nxt;
  logic [3:0]    sh_dp_nxt;
  logic [3:0]    sh_en_nxt;
  logic          wrap;
  logic          load;
  logic          blank_nxt;
  logic          lit_nxt;

  // Registered outputs
  logic [3:0]    num_q;
  logic [3:0]    an_q;
  logic          dp_q;
  logic          frame_start_q;

`ifdef SSEG_SCAN_LZB_EN
  logic          sh_lzb;
  logic          sh_lzb_nxt;
  logic [3:0]    blank_vec;
`else
  logic          unused_lzb;
  assign unused_lzb = bus.lzb;
`endif

  // Next-state and next-output computation; outputs are registered from
  // these so they always match the cnt/digit/shadow state of the same cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wrap       = (cnt == CNT_MAX);
    load       = load_pend || (wrap && (digit == 2'd3));
    cnt_nxt    = cnt;
    digit_nxt  = digit;
    phase_nxt  = phase;
    sh_din_nxt = sh_din;
    sh_dp_nxt  = sh_dp;
    sh_en_nxt  = sh_en;

    if (load_pend) begin
      // First edge after reset: load only, the counter holds at 0.
      cnt_nxt   = '0;
      digit_nxt = 2'd0;
      phase_nxt = PH_GUARD;
    end else if (wrap) begin
      cnt_nxt   = '0;
      digit_nxt = digit + 2'd1;
      phase_nxt = PH_GUARD;
    end else begin
      cnt_nxt = cnt + CW'(1);
      if (cnt_nxt == CNT_GRD) phase_nxt = PH_SHOW;
    end

    if (load) begin
      sh_din_nxt = bus.din;
      sh_dp_nxt  = bus.dp_in;
      sh_en_nxt  = bus.en;
    end

`ifdef SSEG_SCAN_LZB_EN
    sh_lzb_nxt   = load ? bus.lzb : sh_lzb;
    // A digit blanks when it and every digit above it is zero; digit 0 never.
    blank_vec[3] = sh_lzb_nxt && (sh_din_nxt[15:12] == 4'h0);
    blank_vec[2] = blank_vec[3] && (sh_din_nxt[11:8] == 4'h0);
    blank_vec[1] = blank_vec[2] && (sh_din_nxt[7:4] == 4'h0);
    blank_vec[0] = 1'b0;
    blank_nxt    = blank_vec[digit_nxt];
`else
    blank_nxt    = 1'b0;
`endif

    lit_nxt = (phase_nxt == PH_SHOW) && sh_en_nxt[digit_nxt] && !blank_nxt;
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      cnt           <= '0;
      digit         <= 2'd0;
      phase         <= PH_GUARD;
      sh_din        <= '0;
      sh_dp         <= '0;
      sh_en         <= '0;
      load_pend     <= 1'b1;
      num_q         <= 4'h0;
      an_q          <= 4'b1111;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
`ifdef SSEG_SCAN_LZB_EN
      sh_lzb        <= 1'b0;
`endif
    end else begin
      cnt           <= cnt_nxt;
      digit         <= digit_nxt;
      phase         <= phase_nxt;
      sh_din        <= sh_din_nxt;
      sh_dp         <= sh_dp_nxt;
      sh_en         <= sh_en_nxt;
      load_pend     <= 1'b0;
      num_q         <= sh_din_nxt[{digit_nxt, 2'b00} +: 4];
      an_q          <= lit_nxt ? ~(4'b0001 << digit_nxt) : 4'b1111;
      dp_q          <= ~(lit_nxt && sh_dp_nxt[digit_nxt]);
      frame_start_q <= load;
`ifdef SSEG_SCAN_LZB_EN
      sh_lzb        <= sh_lzb_nxt;
`endif
    end
  end

  assign bus.num         = num_q;
  assign bus.an          = an_q;
  assign bus.dp          = dp_q;
  assign bus.digit_sel   = digit;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_sseg_scan.sv
// tb_sseg_scan: directed bench for sseg_scan with TICK_CYCLES=8, GUARD_CYCLES=2.
module tb_sseg_scan;

  localparam int TICK  = 8;
  localparam int GUARD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sseg_scan_if bus ();

  sseg_scan #(.TICK_CYCLES(TICK), .GUARD_CYCLES(GUARD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next frame_start cycle, bounded by a cycle budget.
  task automatic wait_frame(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) found = 1'b1;
    end
    check({tag, "_frame_start_seen"}, {15'd0, found}, 16'd1);
  endtask

  // Walk one full frame starting on a frame_start cycle; ends on the next one.
  task automatic check_frame(input string tag, input logic [15:0] val,
                             input logic [3:0] en_e, input logic [3:0] dp_e,
                             input logic [3:0] blank_e);
    for (int k = 0; k < 4 * TICK; k++) begin
      int   d;
      logic lit;
      d   = k / TICK;
      lit = ((k % TICK) >= GUARD) && en_e[d] && !blank_e[d];
      check($sformatf("%s_an_k%0d", tag, k), {12'd0, bus.an},
            {12'd0, lit ? ~(4'b0001 << d) : 4'b1111});
      check($sformatf("%s_num_k%0d", tag, k), {12'd0, bus.num}, {12'd0, val[4*d +: 4]});
      check($sformatf("%s_dp_k%0d", tag, k), {15'd0, bus.dp}, {15'd0, ~(lit && dp_e[d])});
      check($sformatf("%s_sel_k%0d", tag, k), {14'd0, bus.digit_sel}, 16'(d));
      check($sformatf("%s_fs_k%0d", tag, k), {15'd0, bus.frame_start}, {15'd0, k == 0});
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset with 1234 presented.
    bus.din = 16'h1234; bus.dp_in = 4'b0000; bus.en = 4'b1111; bus.lzb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", {12'd0, bus.an}, 16'h000F);
    check("rst_dp", {15'd0, bus.dp}, 16'd1);
    check("rst_num", {12'd0, bus.num}, 16'd0);
    check("rst_sel", {14'd0, bus.digit_sel}, 16'd0);
    check("rst_fs", {15'd0, bus.frame_start}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_fs", {15'd0, bus.frame_start}, 16'd1);
    check("rel_num", {12'd0, bus.num}, 16'h0004);
    check("rel_an", {12'd0, bus.an}, 16'h000F);
    check("rel_sel", {14'd0, bus.digit_sel}, 16'd0);

    // Scan order.
    bus.din = 16'hA5C3;
    wait_frame("scan");
    check_frame("scan", 16'hA5C3, 4'b1111, 4'b0000, 4'b0000);
    check("scan_repeat_fs", {15'd0, bus.frame_start}, 16'd1);

    // Frame latch: input change at digit 1 must wait for the next frame.
    bus.din = 16'h1111;
    wait_frame("latch");
    for (int k = 0; k < 10; k++) begin
      check($sformatf("latch_pre_num_k%0d", k), {12'd0, bus.num}, 16'h0001);
      @(negedge clk);
    end
    check("latch_sel_d1", {14'd0, bus.digit_sel}, 16'd1);
    bus.din = 16'h2222;
    for (int k = 10; k < 4 * TICK; k++) begin
      check($sformatf("latch_hold_num_k%0d", k), {12'd0, bus.num}, 16'h0001);
      @(negedge clk);
    end
    check("latch_new_fs", {15'd0, bus.frame_start}, 16'd1);
    check("latch_new_num", {12'd0, bus.num}, 16'h0002);
    check_frame("latch2", 16'h2222, 4'b1111, 4'b0000, 4'b0000);

    // Per-digit enable and decimal point.
    bus.din = 16'h4321; bus.en = 4'b0101; bus.dp_in = 4'b0100;
    wait_frame("endp");
    check_frame("endp", 16'h4321, 4'b0101, 4'b0100, 4'b0000);
    bus.en = 4'b1111; bus.dp_in = 4'b1111;

`ifdef SSEG_SCAN_LZB_EN
    // Leading-zero blanking; blanked digits also hide their dp.
    bus.din = 16'h0030; bus.lzb = 1'b1;
    wait_frame("lzb30");
    check_frame("lzb30", 16'h0030, 4'b1111, 4'b1111, 4'b1100);
    bus.din = 16'h0000;
    wait_frame("lzb00");
    check_frame("lzb00", 16'h0000, 4'b1111, 4'b1111, 4'b1110);
    bus.lzb = 1'b0;
    wait_frame("lzboff");
    check_frame("lzboff", 16'h0000, 4'b1111, 4'b1111, 4'b0000);
`endif

    // Async reset in digit 2 SHOW at cnt 5.
    bus.din = 16'hBEEF; bus.dp_in = 4'b0000;
    wait_frame("arst");
    repeat (2 * TICK + 5) @(negedge clk);
    check("arst_pre_an", {12'd0, bus.an}, 16'h000B);
    check("arst_pre_sel", {14'd0, bus.digit_sel}, 16'd2);
    #1 rst = 1'b0;
    #1;
    check("arst_an", {12'd0, bus.an}, 16'h000F);
    check("arst_sel", {14'd0, bus.digit_sel}, 16'd0);
    check("arst_num", {12'd0, bus.num}, 16'd0);
    check("arst_dp", {15'd0, bus.dp}, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_frame("arst_post", 16'hBEEF, 4'b1111, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan.md
# sseg_scan

Time-multiplexed scanner for the 4-digit seven-segment display. It latches a 16-bit hex value once per frame and walks the four digits in turn. For each digit it drives the 4-bit nibble into the existing `sseg_decoder` (`num` port) along with an active-low anode one-hot and decimal point. A guard interval between digits suppresses ghosting.

## Interface
- `TICK_CYCLES`, 100000: clock cycles per digit slot (≥ 4).
- `GUARD_CYCLES`, 1000: cycles at the start of each slot with all anodes off (1 ≤ GUARD_CYCLES < TICK_CYCLES).
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `din` in 16: digit3..digit0 = din[15:12]..din[3:0].
- `dp_in` in 4: decimal point request per digit, 1 = lit.
- `en` in 4: digit enable per digit, 1 = digit may light.
- `lzb` in 1: request leading-zero blanking (used only with `SSEG_SCAN_LZB_EN`).
- `num` out 4: nibble for `sseg_decoder.num`.
- `an` out 4: anodes, active-low, at most one bit 0.
- `dp` out 1: decimal point, active-low.
- `digit_sel` out 2: index of the digit currently scanned.
- `frame_start` out 1: one-cycle pulse on the cycle the shadow registers load.

## Operation
- State:
  - `cnt` counts 0..TICK_CYCLES-1 and wraps.
  - `digit` is 0..3 and advances when `cnt` wraps (3 wraps to 0).
  - Shadow registers `sh_din`, `sh_dp`, `sh_en` hold the latched inputs.
  - `load_pend` flag.
- Phase FSM, derived from `cnt`:
  - GUARD while `cnt < GUARD_CYCLES`. SHOW otherwise.
  - GUARD → SHOW at `cnt == GUARD_CYCLES`.
  - SHOW → GUARD on wrap.
- Shadow load:
  - Loads on the edge where `cnt == TICK_CYCLES-1` and `digit == 3`, i.e. on entry to digit 0.
  - Also loads on the first edge after reset release (`load_pend` = 1 at reset, cleared by that load).
  - The inputs are never observed mid-frame, so no tearing.
- `frame_start` = 1 in the cycle following a shadow load, concurrent with `cnt == 0`, `digit == 0`.
- Outputs are registered and correspond to the current `cnt`/`digit`/shadow state:
  - `digit_sel` = `digit`.
  - `num` = `sh_din[4*digit +: 4]`, valid in both phases.
  - `lit` = SHOW and `sh_en[digit]` and not `blank(digit)`.
  - `an` = ~(lit ? 1 << digit : 0).
  - `dp` = ~(lit and `sh_dp[digit]`).
- `blank(d)` = 0 unless `SSEG_SCAN_LZB_EN` is defined (see Configuration).
- Input changes between loads have no effect on any output.

## Timing
- Reset (async, `rst` = 0): `an` = 4'b1111, `dp` = 1, `num` = 0, `digit_sel` = 0, `frame_start` = 0, `cnt` = 0, `digit` = 0, shadows = 0, `load_pend` = 1.
- A reset asserted mid-slot forces the reset values immediately. There is no partial frame afterwards.
- First edge after release:
  - Shadow loads, `cnt` stays 0.
  - The next cycle shows `frame_start` = 1 with digit 0 in GUARD.
- Slot length is exactly `TICK_CYCLES`. The anode is low for exactly `TICK_CYCLES - GUARD_CYCLES` cycles per slot.
- Frame period = 4·TICK_CYCLES. Loads are exactly 4·TICK_CYCLES apart, except the post-reset one.
- `an` never has two zero bits in any cycle, including across slot boundaries, where GUARD forces 1111.
- `sseg_decoder` is combinational, so segments follow `num` with no added latency.

## Configuration
- `SSEG_SCAN_LZB_EN` defined:
  - When `lzb` = 1 (sampled into the shadow at load), `blank(d)` = 1 for d ∈ {3,2,1} iff `sh_din` nibbles d..3 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit also suppresses its `dp`.
- `SSEG_SCAN_LZB_EN` undefined:
  - `lzb` is ignored and `blank` ≡ 0.
  - No LZB logic is synthesized.

## Test plan
Bench parameters: TICK_CYCLES = 8, GUARD_CYCLES = 2.

- Reset: hold `rst` = 0 with `din` = 16'h1234. Expect `an` = 1111, `dp` = 1, `num` = 0, `digit_sel` = 0. After release, `frame_start` pulses one cycle later and `num` = 4.
- Scan order: `din` = 16'hA5C3, `en` = 1111, `dp_in` = 0. The `an` pattern is 1111 ×2, then 1110 ×6 with `num` = 3, followed by 1101/C, 1011/5, 0111/A, then repeats every 32 cycles. `dp` stays 1.
- Frame latch: change `din` 16'h1111 → 16'h2222 mid-frame at digit 1. `num` stays 1 until the next `frame_start`, then shows 2.
- Enable/dp: `en` = 0101, `dp_in` = 0100. `an` goes low only in the digit 0 and digit 2 slots. `dp` = 0 only during the digit 2 SHOW phase.
- LZB (macro defined): `din` = 16'h0030, `lzb` = 1. Digits 3 and 2 are dark and digits 1 and 0 are lit. With `din` = 16'h0000, only digit 0 lights. With `lzb` = 0, all four light.
- Async reset mid-slot: assert `rst` in digit 2 SHOW at `cnt` = 5. `an` = 1111 within the same cycle. After release, scanning restarts at digit 0 with `cnt` = 0.
